// File: rtl/dorow_lut_loader.sv
// dorow_lut_loader: builds the four GF(2^8) x2/x3 tables with xtime and streams them over the DoRow config bus.
// Optional read-back pass after the writes: define DOROW_LUT_LOADER_VERIFY_EN.
module dorow_lut_loader #(
   parameter int NUM_ENTRIES = 256,
   parameter int TIMEOUT     = 16,
   parameter int DATA_W      = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [9:0]          err_addr,
   output logic                valid,
   output logic [9:0]          addr,
   output logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   wdata,
   input  logic                ready,
   input  logic [DATA_W-1:0]   rdata
);

   localparam int               WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [7:0]       IDX_LAST  = 8'(NUM_ENTRIES - 1);

`ifdef DOROW_LUT_LOADER_VERIFY_EN
   typedef enum logic [1:0] {IDLE, WRITE, VERIFY, FINISH} state_t;
`else
   typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;
`endif

   state_t            state_q, state_d;
   logic [1:0]        unit_q;
   logic [7:0]        idx_q;
   logic [WAIT_W-1:0] wait_q;
   logic [1:0]        unit_sel;
   logic [7:0]        x2, entry;
   logic              xfer, last_entry, timeout_hit, mismatch;

   // Unit step 0..3 maps to bus select 11, 01, 10, 00; steps 0/1 are mul2, 2/3 are mul3.
   assign unit_sel = {~unit_q[0], ~unit_q[1]};
   assign x2       = {idx_q[6:0], 1'b0} ^ (idx_q[7] ? 8'h1B : 8'h00);
   assign entry    = unit_q[1] ? (x2 ^ idx_q) : x2;

`ifdef DOROW_LUT_LOADER_VERIFY_EN
   assign busy     = (state_q == WRITE) || (state_q == VERIFY);
   assign mismatch = (state_q == VERIFY) && xfer &&
                     (rdata != {{(DATA_W-8){1'b0}}, entry});
`else
   logic unused_rdata;
   assign busy         = (state_q == WRITE);
   assign mismatch     = 1'b0;
   assign unused_rdata = ^rdata;
`endif

   // Handshake: a request is held (addr/wstrb/wdata stable) from the cycle valid rises until the
   // cycle valid && ready; the next request, if any, is presented in the following cycle.
   assign valid = busy;
   assign done  = (state_q == FINISH);
   assign addr  = valid ? {unit_sel, idx_q} : 10'h000;
   assign wdata = valid ? {{(DATA_W-8){1'b0}}, entry} : {DATA_W{1'b0}};
   assign wstrb = (state_q == WRITE) ? {(DATA_W/8){1'b1}} : {(DATA_W/8){1'b0}};

   assign xfer        = valid && ready;
   assign last_entry  = (unit_q == 2'd3) && (idx_q == IDX_LAST);
   assign timeout_hit = valid && !ready && (wait_q == WAIT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = WRITE;
         end
         WRITE: begin
            if (timeout_hit) begin
               state_d = FINISH;
            end else if (xfer && last_entry) begin
`ifdef DOROW_LUT_LOADER_VERIFY_EN
               state_d = VERIFY;
`else
               state_d = FINISH;
`endif
            end
         end
`ifdef DOROW_LUT_LOADER_VERIFY_EN
         VERIFY: begin
            if (timeout_hit || mismatch || (xfer && last_entry)) state_d = FINISH;
         end
`endif
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         unit_q   <= 2'd0;
         idx_q    <= 8'd0;
         wait_q   <= '0;
         error    <= 1'b0;
         err_addr <= 10'h000;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && start) begin
            unit_q   <= 2'd0;
            idx_q    <= 8'd0;
            wait_q   <= '0;
            error    <= 1'b0;
            err_addr <= 10'h000;
         end else if (busy) begin
            if (xfer) begin
               wait_q <= '0;
               // Unit step wraps 3 -> 0, which also rewinds the address walk for the read-back pass.
               if (idx_q == IDX_LAST) begin
                  idx_q  <= 8'd0;
                  unit_q <= unit_q + 2'd1;
               end else begin
                  idx_q <= idx_q + 8'd1;
               end
            end else begin
               wait_q <= wait_q + WAIT_W'(1);
            end
            if (timeout_hit || mismatch) begin
               error    <= 1'b1;
               err_addr <= addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_dorow_lut_loader.sv
// Bench for dorow_lut_loader: responder with selectable backpressure, GF(2^8) reference model, transfer scoreboard.
`timescale 1ns/1ps
module tb_dorow_lut_loader;

   localparam int NUM_ENTRIES = 256;
   localparam int TIMEOUT     = 16;
   localparam int DATA_W      = 32;
   localparam int W           = 46;
   localparam int N_TOTAL     = 4 * NUM_ENTRIES;
`ifdef DOROW_LUT_LOADER_VERIFY_EN
   localparam int N_XFER      = 2 * N_TOTAL;
`else
   localparam int N_XFER      = N_TOTAL;
`endif
   localparam int LOAD_LAT    = N_XFER + 1;
   localparam int BUDGET      = 6000;

   logic        clk = 1'b0;
   logic        rst, start, ready;
   logic        busy, done, error, valid;
   logic [9:0]  err_addr, addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata, rdata;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int t_start = 0;
   int comp_cnt = 0;
   int mode = 0;
   bit corrupt = 1'b0;
   int req_num = 0;
   int stall_left = 0;
   int low_run = 0;
   int n_stall = 0;
   bit prev_valid = 1'b0;
   bit prev_ready = 1'b0;
   bit stalled_prev = 1'b0;
   logic [W-1:0] held, got, exp_v;
   logic [W-1:0] exp_q[$];
   logic [7:0]   seen[1024];
   logic [7:0]   mem[1024];

   dorow_lut_loader #(.NUM_ENTRIES(NUM_ENTRIES), .TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
      .err_addr(err_addr), .valid(valid), .addr(addr), .wstrb(wstrb), .wdata(wdata),
      .ready(ready), .rdata(rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Responder: 0 always ready, 1 every 5th request stalls 3 cycles, 2 never accepts 10'h305, 3 random.
   initial begin
      bit new_req;
      ready = 1'b0;
      rdata = '0;
      forever begin
         @(posedge clk); #1;
         new_req = valid && (!prev_valid || prev_ready);
         case (mode)
            0: ready = 1'b1;
            1: begin
               if (new_req) begin
                  req_num++;
                  if (req_num % 5 == 0) stall_left = 3;
               end
               ready = (stall_left == 0);
               if (stall_left > 0) stall_left--;
            end
            2: ready = !(valid && addr == 10'h305);
            default: begin
               ready = (low_run >= 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
               low_run = (valid && !ready) ? low_run + 1 : 0;
            end
         endcase
         if (mode != 1 && new_req) req_num++;
         if (valid && !ready) n_stall++;
         if (valid && wstrb == 4'h0)
            rdata = (corrupt && addr == 10'h080) ? 32'h0 : {24'h0, mem[addr]};
         else
            rdata = $urandom;
         prev_valid = valid;
         prev_ready = ready;
      end
   end

   // Scoreboard: every completed transfer must be the next expected one; stalled requests must hold.
   always @(negedge clk) begin
      if (valid) begin
         if (stalled_prev) begin
            n_checks++;
            if ({wstrb, addr, wdata} !== held) begin
               n_errors++;
               $display("FAIL hold_stable: got %h, required %h", {wstrb, addr, wdata}, held);
            end
         end
         if (ready) begin
            got = {wstrb, addr, wdata};
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL extra_xfer: got %h, required none", got);
            end else begin
               exp_v = exp_q.pop_front();
               if (got !== exp_v) begin
                  n_errors++;
                  $display("FAIL xfer_%0d: got %h, required %h", comp_cnt, got, exp_v);
               end
            end
            comp_cnt++;
            if (wstrb == 4'hF) begin
               seen[addr] = wdata[7:0];
               mem[addr]  = wdata[7:0];
            end
         end
         stalled_prev = !ready;
         held = {wstrb, addr, wdata};
      end else begin
         stalled_prev = 1'b0;
      end
   end

   function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   task automatic build_model();
      logic [1:0] sel [4];
      int         fac [4];
      logic [3:0] strb;
      logic [7:0] i8;
      sel = '{2'b11, 2'b01, 2'b10, 2'b00};
      fac = '{2, 2, 3, 3};
      exp_q.delete();
      for (int pass = 0; pass < N_XFER / N_TOTAL; pass++) begin
         strb = (pass == 0) ? 4'hF : 4'h0;
         for (int u = 0; u < 4; u++)
            for (int i = 0; i < NUM_ENTRIES; i++) begin
               i8 = 8'(i);
               exp_q.push_back({strb, sel[u], i8, 24'h0, gf_mul(i8, 8'(fac[u]))});
            end
      end
   endtask

   task automatic clear_sb();
      comp_cnt = 0; req_num = 0; stall_left = 0; low_run = 0; n_stall = 0;
      corrupt = 1'b0; stalled_prev = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      t_start = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output bit busy_bad);
      lat = -1;
      busy_bad = 1'b0;
      for (int n = 0; n < BUDGET; n++) begin
         @(negedge clk); #1;
         if (done) begin
            lat = cyc - t_start;
            break;
         end
         if (!busy) busy_bad = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      n_checks++;
      if ({busy, done, error, valid} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_flags: got busy/done/error/valid=%b, required 0000", {busy, done, error, valid});
      end
      n_checks++;
      if ({err_addr, addr} !== 20'h0) begin
         n_errors++;
         $display("FAIL reset_addr: got err_addr=%h addr=%h, required 0/0", err_addr, addr);
      end
      n_checks++;
      if ({wstrb, wdata} !== 36'h0) begin
         n_errors++;
         $display("FAIL reset_data: got wstrb=%h wdata=%h, required 0/0", wstrb, wdata);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_basic_load();
      int lat; bit busy_bad;
      logic [9:0] sa [5];
      logic [7:0] sv [5];
      sa = '{10'h380, 10'h257, 10'h157, 10'h0FF, 10'h3FF};
      sv = '{8'h1B, 8'hF9, 8'hAE, 8'h1A, 8'hE5};
      clear_sb(); mode = 0; build_model();
      pulse_start();
      wait_done(lat, busy_bad);
      n_checks++;
      if (lat != LOAD_LAT) begin
         n_errors++;
         $display("FAIL basic_latency: got %0d, required %0d", lat, LOAD_LAT);
      end
      n_checks++;
      if (busy_bad) begin
         n_errors++;
         $display("FAIL basic_busy: got busy low during load, required high");
      end
      n_checks++;
      if ({busy, valid, error} !== 3'b000) begin
         n_errors++;
         $display("FAIL basic_done_flags: got busy/valid/error=%b, required 000", {busy, valid, error});
      end
      n_checks++;
      if (comp_cnt != N_XFER || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL basic_count: got %0d xfers (%0d left), required %0d (0 left)", comp_cnt, exp_q.size(), N_XFER);
      end
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (seen[sa[k]] !== sv[k]) begin
            n_errors++;
            $display("FAIL basic_value_%h: got %h, required %h", sa[k], seen[sa[k]], sv[k]);
         end
      end
      @(negedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_done_pulse: got done=%b a cycle later, required 0", done);
      end
   endtask

   task automatic test_backpressure();
      int lat; bit busy_bad;
      clear_sb(); mode = 1; build_model();
      pulse_start();
      wait_done(lat, busy_bad);
      n_checks++;
      if (lat != LOAD_LAT + 3 * (N_XFER / 5)) begin
         n_errors++;
         $display("FAIL bp_latency: got %0d, required %0d", lat, LOAD_LAT + 3 * (N_XFER / 5));
      end
      n_checks++;
      if (comp_cnt != N_XFER || req_num != N_XFER || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL bp_count: got %0d xfers %0d requests, required %0d", comp_cnt, req_num, N_XFER);
      end
      n_checks++;
      if (error !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_error: got %b, required 0", error);
      end
   endtask

   task automatic test_timeout();
      int lat; int stall_cyc; bit busy_bad;
      clear_sb(); mode = 2; build_model();
      pulse_start();
      lat = -1; stall_cyc = 0;
      for (int n = 0; n < BUDGET; n++) begin
         @(negedge clk); #1;
         if (done) begin
            lat = cyc - t_start;
            break;
         end
         if (valid && !ready) stall_cyc++;
      end
      n_checks++;
      if (lat != 5 + TIMEOUT + 1 || stall_cyc != TIMEOUT) begin
         n_errors++;
         $display("FAIL to_timing: got done at +%0d after %0d waits, required +%0d after %0d", lat, stall_cyc, 5 + TIMEOUT + 1, TIMEOUT);
      end
      n_checks++;
      if (error !== 1'b1 || err_addr !== 10'h305) begin
         n_errors++;
         $display("FAIL to_error: got error=%b err_addr=%h, required 1/305", error, err_addr);
      end
      n_checks++;
      if (valid !== 1'b0 || comp_cnt != 5 || exp_q.size() != N_XFER - 5) begin
         n_errors++;
         $display("FAIL to_state: got valid=%b xfers=%0d, required 0/5", valid, comp_cnt);
      end
      clear_sb(); mode = 0; build_model();
      pulse_start();
      n_checks++;
      if (error !== 1'b0 || err_addr !== 10'h000) begin
         n_errors++;
         $display("FAIL to_clear: got error=%b err_addr=%h after start, required 0/000", error, err_addr);
      end
      wait_done(lat, busy_bad);
      n_checks++;
      if (lat != LOAD_LAT || error !== 1'b0) begin
         n_errors++;
         $display("FAIL to_reload: got lat=%0d error=%b, required %0d/0", lat, error, LOAD_LAT);
      end
   endtask

   task automatic test_control();
      int lat; bit busy_bad; bit saw_done;
      clear_sb(); mode = 0; build_model();
      pulse_start();
      for (int n = 0; n < BUDGET; n++) begin
         @(negedge clk); #1;
         if (comp_cnt >= 500) break;
      end
      rst = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if ({valid, busy, done} !== 3'b000) begin
         n_errors++;
         $display("FAIL ctl_reset: got valid/busy/done=%b, required 000", {valid, busy, done});
      end
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (5) begin
         @(negedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done) begin
         n_errors++;
         $display("FAIL ctl_no_done: got done pulse after reset, required none");
      end
      clear_sb(); build_model();
      pulse_start();
      for (int n = 0; n < BUDGET; n++) begin
         @(negedge clk); #1;
         if (comp_cnt >= 100) break;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(lat, busy_bad);
      n_checks++;
      if (lat != LOAD_LAT || comp_cnt != N_XFER || exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL ctl_busy_start: got lat=%0d xfers=%0d, required %0d/%0d", lat, comp_cnt, LOAD_LAT, N_XFER);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         n_errors++;
         $display("FAIL ctl_finish_start: got busy=%b valid=%b, required 0/0", busy, valid);
      end
   endtask

   task automatic test_random();
      int lat; bit busy_bad;
      for (int it = 0; it < 2; it++) begin
         clear_sb(); mode = 3; build_model();
         repeat ($urandom_range(1, 6)) @(posedge clk);
         pulse_start();
         wait_done(lat, busy_bad);
         n_checks++;
         if (lat != LOAD_LAT + n_stall || error !== 1'b0) begin
            n_errors++;
            $display("FAIL rand_%0d_latency: got lat=%0d error=%b, required %0d/0", it, lat, error, LOAD_LAT + n_stall);
         end
         n_checks++;
         if (comp_cnt != N_XFER || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rand_%0d_count: got %0d xfers, required %0d", it, comp_cnt, N_XFER);
         end
      end
   endtask

`ifdef DOROW_LUT_LOADER_VERIFY_EN
   task automatic test_verify();
      int lat; bit busy_bad;
      int exp_comp;
      exp_comp = N_TOTAL + 3 * NUM_ENTRIES + 129;
      clear_sb(); mode = 0; build_model();
      corrupt = 1'b1;
      pulse_start();
      wait_done(lat, busy_bad);
      n_checks++;
      if (lat != exp_comp + 1 || comp_cnt != exp_comp) begin
         n_errors++;
         $display("FAIL verify_timing: got lat=%0d xfers=%0d, required %0d/%0d", lat, comp_cnt, exp_comp + 1, exp_comp);
      end
      n_checks++;
      if (error !== 1'b1 || err_addr !== 10'h080 || valid !== 1'b0) begin
         n_errors++;
         $display("FAIL verify_error: got error=%b err_addr=%h valid=%b, required 1/080/0", error, err_addr, valid);
      end
      corrupt = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      start = 1'b0;
      test_reset();
      test_basic_load();
      test_backpressure();
      test_timeout();
      test_control();
      test_random();
`ifdef DOROW_LUT_LOADER_VERIFY_EN
      test_verify();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
